// File: rtl/cache_nway.sv
`default_nettype none
// ============================================================================
// Module : cache_nway
// N-way set-associative write-back/write-allocate cache with tree pseudo-LRU.
// Rev    : 1.0
// ============================================================================
module cache_nway #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int n_ways   = 2,
  parameter int s_tag    = 32 - s_offset - s_index,
  parameter int s_line   = 8 * 2**s_offset
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       cpu_mem_address,
  input  logic              cpu_mem_read,
  input  logic              cpu_mem_write,
  input  logic [3:0]        cpu_mem_byte_enable,
  input  logic [31:0]       cpu_mem_wdata,
  output logic [31:0]       cpu_mem_rdata,
  output logic              cpu_mem_resp,
  output logic [31:0]       ca_mem_address,
  output logic              ca_mem_read,
  output logic              ca_mem_write,
  output logic [s_line-1:0] ca_mem_wdata,
  input  logic [s_line-1:0] ca_mem_rdata,
  input  logic              ca_mem_resp,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);
  localparam int c_SETS = 2**s_index;
  localparam int c_LG   = (n_ways > 1) ? $clog2(n_ways) : 1;
  localparam int c_PL   = (n_ways > 1) ? n_ways - 1 : 1;
  localparam int c_WS   = s_offset - 2;

  typedef enum logic [1:0] {
    ST_CHECK     = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_valid [c_SETS][n_ways];
  logic              r_dirty [c_SETS][n_ways];
  logic [s_tag-1:0]  r_tag   [c_SETS][n_ways];
  logic [s_line-1:0] r_data  [c_SETS][n_ways];
  logic [c_PL-1:0]   r_plru  [c_SETS];
  logic [c_LG-1:0]   r_victim;
  logic              r_fill;
  logic [31:0]       r_hit_count;
  logic [31:0]       r_miss_count;

  logic [s_tag-1:0]   w_tag;
  logic [s_index-1:0] w_idx;
  logic [c_WS-1:0]    w_word;
  logic               w_req;
  logic               w_hit;
  logic [c_LG-1:0]    w_hit_way;
  logic               w_found;
  logic [c_LG-1:0]    w_victim;
  logic [c_PL-1:0]    w_plru_nxt;
  logic [s_line-1:0]  w_line;
  logic [s_line-1:0]  w_merged;
  logic               w_unused;

  assign w_tag    = cpu_mem_address[31 -: s_tag];
  assign w_idx    = cpu_mem_address[s_offset +: s_index];
  assign w_word   = cpu_mem_address[2 +: c_WS];
  assign w_req    = cpu_mem_read | cpu_mem_write;
  assign w_unused = ^cpu_mem_address[1:0];

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < n_ways; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = c_LG'(w);
      end
    end
  end

  // Invalid ways are filled lowest-first; only a full set consults the tree.
  always_comb begin : vict
    int node;
    node     = 0;
    w_found  = 1'b0;
    w_victim = '0;
    for (int w = 0; w < n_ways; w++) begin
      if (!w_found && !r_valid[w_idx][w]) begin
        w_found  = 1'b1;
        w_victim = c_LG'(w);
      end
    end
    if (!w_found && (n_ways > 1)) begin
      for (int l = c_LG - 1; l >= 0; l--) begin
        w_victim[l] = r_plru[w_idx][c_LG'(node)];
        node        = 2 * node + 1 + int'(r_plru[w_idx][c_LG'(node)]);
      end
    end
  end

  always_comb begin : touch
    int node;
    node       = 0;
    w_plru_nxt = r_plru[w_idx];
    if (n_ways > 1) begin
      for (int l = c_LG - 1; l >= 0; l--) begin
        w_plru_nxt[c_LG'(node)] = ~w_hit_way[l];
        node                    = 2 * node + 1 + int'(w_hit_way[l]);
      end
    end
  end

  always_comb begin
    w_line   = r_data[w_idx][w_hit_way];
    w_merged = w_line;
    for (int b = 0; b < 4; b++) begin
      if (cpu_mem_byte_enable[b])
        w_merged[{w_word, 2'(b), 3'b000} +: 8] = cpu_mem_wdata[8*b +: 8];
    end
  end

  assign cpu_mem_rdata  = w_line[{w_word, 5'b00000} +: 32];
  assign cpu_mem_resp   = (r_state == ST_CHECK) && w_req && w_hit;
  assign ca_mem_read    = (r_state == ST_ALLOCATE);
  assign ca_mem_write   = (r_state == ST_WRITEBACK);
  assign ca_mem_address = (r_state == ST_WRITEBACK)
                        ? {r_tag[w_idx][r_victim], w_idx, {s_offset{1'b0}}}
                        : {w_tag, w_idx, {s_offset{1'b0}}};
  assign ca_mem_wdata   = r_data[w_idx][r_victim];
  assign hit_count      = r_hit_count;
  assign miss_count     = r_miss_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_CHECK;
      r_victim     <= '0;
      r_fill       <= 1'b0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
      for (int s = 0; s < c_SETS; s++) begin
        r_plru[s] <= '0;
        for (int w = 0; w < n_ways; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
        end
      end
    end else begin
      case (r_state)
        ST_CHECK: begin
          if (w_req && w_hit) begin
            r_plru[w_idx] <= w_plru_nxt;
            if (cpu_mem_write) r_dirty[w_idx][w_hit_way] <= 1'b1;
            // The completion that follows a fill was already counted as a miss.
            if (!r_fill) r_hit_count <= r_hit_count + 32'd1;
            r_fill <= 1'b0;
          end else if (w_req) begin
            r_miss_count <= r_miss_count + 32'd1;
            r_victim     <= w_victim;
            r_state      <= (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim])
                          ? ST_WRITEBACK : ST_ALLOCATE;
          end
        end
        ST_WRITEBACK: begin
          if (ca_mem_resp) r_state <= ST_ALLOCATE;
        end
        ST_ALLOCATE: begin
          if (ca_mem_resp) begin
            r_tag[w_idx][r_victim]   <= w_tag;
            r_valid[w_idx][r_victim] <= 1'b1;
            r_dirty[w_idx][r_victim] <= 1'b0;
            r_fill                   <= 1'b1;
            r_state                  <= ST_CHECK;
          end
        end
        default: r_state <= ST_CHECK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if ((r_state == ST_CHECK) && w_req && w_hit && cpu_mem_write)
        r_data[w_idx][w_hit_way] <= w_merged;
      else if ((r_state == ST_ALLOCATE) && ca_mem_resp)
        r_data[w_idx][r_victim] <= ca_mem_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_nway.sv
`default_nettype none
// ============================================================================
// Module : tb_cache_nway
// Self-checking bench for cache_nway against a set/way/tree reference model.
// Rev    : 1.0
// ============================================================================
module tb_cache_nway;
  localparam int NW = 4;
  localparam int LG = 2;

  logic         clk, rst;
  logic [31:0]  addr, wdata, rdata, ca_addr, hitc, missc;
  logic         rd, wr, resp, ca_rd, ca_wr, ca_resp;
  logic [3:0]   be;
  logic [255:0] ca_wdata, ca_rdata;

  logic [31:0]  d1_addr, d1_rdout, d1_caaddr, d1_hitc, d1_missc;
  logic         d1_rd, d1_wr, d1_cresp, d1_ca_rd, d1_ca_wr, d1_resp;
  logic [255:0] d1_ca_wdata, d1_rdata;

  cache_nway #(.s_offset(5), .s_index(3), .n_ways(NW)) u_dut (
    .clk(clk), .rst(rst), .cpu_mem_address(addr), .cpu_mem_read(rd),
    .cpu_mem_write(wr), .cpu_mem_byte_enable(be), .cpu_mem_wdata(wdata),
    .cpu_mem_rdata(rdata), .cpu_mem_resp(resp), .ca_mem_address(ca_addr),
    .ca_mem_read(ca_rd), .ca_mem_write(ca_wr), .ca_mem_wdata(ca_wdata),
    .ca_mem_rdata(ca_rdata), .ca_mem_resp(ca_resp), .hit_count(hitc),
    .miss_count(missc));

  cache_nway #(.s_offset(5), .s_index(3), .n_ways(1)) u_dut1 (
    .clk(clk), .rst(rst), .cpu_mem_address(d1_addr), .cpu_mem_read(d1_rd),
    .cpu_mem_write(d1_wr), .cpu_mem_byte_enable(4'b0000), .cpu_mem_wdata(32'd0),
    .cpu_mem_rdata(d1_rdout), .cpu_mem_resp(d1_cresp), .ca_mem_address(d1_caaddr),
    .ca_mem_read(d1_ca_rd), .ca_mem_write(d1_ca_wr), .ca_mem_wdata(d1_ca_wdata),
    .ca_mem_rdata(d1_rdata), .ca_mem_resp(d1_resp), .hit_count(d1_hitc),
    .miss_count(d1_missc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [255:0] init_line(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = a ^ (w * 32'h01010101) ^ 32'h5A000000;
    return l;
  endfunction

  // Memory seen by the DUT (written by its writebacks) and the model's own copy.
  logic [255:0] mem   [logic [31:0]];
  logic [255:0] m_mem [logic [31:0]];

  function automatic logic [255:0] mem_get(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return init_line(a);
  endfunction

  function automatic logic [255:0] model_mem(input logic [31:0] a);
    if (m_mem.exists(a)) return m_mem[a];
    return init_line(a);
  endfunction

  int rsp_cnt = 0, rsp_delay = 0, fix_delay = -1;

  task automatic set_delay(input int d);
    fix_delay = d;
    rsp_delay = (d >= 0) ? d : 0;
  endtask

  initial begin
    ca_resp  = 1'b0;
    ca_rdata = '0;
    forever begin
      @(posedge clk); #1;
      ca_resp = 1'b0;
      if (rst || !(ca_rd || ca_wr)) rsp_cnt = 0;
      else if (rsp_cnt >= rsp_delay) begin
        ca_resp = 1'b1;
        if (ca_wr) mem[ca_addr] = ca_wdata;
        else ca_rdata = mem_get(ca_addr);
        rsp_cnt   = 0;
        rsp_delay = (fix_delay >= 0) ? fix_delay : int'($urandom_range(0, 3));
      end else rsp_cnt++;
    end
  end

  initial begin
    d1_resp  = 1'b0;
    d1_rdata = '0;
    forever begin
      @(posedge clk); #1;
      d1_resp  = !rst && (d1_ca_rd || d1_ca_wr) && !d1_resp;
      d1_rdata = {8{d1_caaddr}};
    end
  end

  // Reference model: per set/way contents plus heap-indexed PLRU node bits.
  bit           m_valid [8][NW];
  bit           m_dirty [8][NW];
  logic [23:0]  m_tag   [8][NW];
  logic [255:0] m_line  [8][NW];
  bit           m_tree  [8][NW-1];
  int           m_hits, m_misses;
  bit           exp_hit, exp_wb;
  logic [31:0]  exp_wb_addr, exp_fill_addr, exp_rdata;
  logic [255:0] exp_wb_line;

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      for (int w = 0; w < NW; w++) begin m_valid[s][w] = 0; m_dirty[s][w] = 0; end
      for (int n = 0; n < NW - 1; n++) m_tree[s][n] = 0;
    end
    m_hits = 0; m_misses = 0;
  endtask

  task automatic model_access(input logic [31:0] a, input bit is_wr,
                              input logic [3:0] b, input logic [31:0] d);
    int s, hw, v, node, wd, bt;
    logic [23:0] t;
    s = int'(a[7:5]); t = a[31:8]; wd = int'(a[4:2]);
    hw = -1;
    for (int i = 0; i < NW; i++) if (m_valid[s][i] && m_tag[s][i] == t) hw = i;
    exp_hit = (hw >= 0);
    exp_wb = 0;
    exp_fill_addr = {a[31:5], 5'b00000};
    if (hw < 0) begin
      m_misses++;
      v = -1;
      for (int i = NW - 1; i >= 0; i--) if (!m_valid[s][i]) v = i;
      if (v < 0) begin
        node = 0; v = 0;
        for (int l = 0; l < LG; l++) begin
          v = v * 2 + int'(m_tree[s][node]);
          node = 2 * node + 1 + int'(m_tree[s][node]);
        end
      end
      if (m_valid[s][v] && m_dirty[s][v]) begin
        exp_wb      = 1;
        exp_wb_addr = {m_tag[s][v], a[7:5], 5'b00000};
        exp_wb_line = m_line[s][v];
        m_mem[exp_wb_addr] = m_line[s][v];
      end
      m_line[s][v]  = model_mem(exp_fill_addr);
      m_tag[s][v]   = t;
      m_valid[s][v] = 1;
      m_dirty[s][v] = 0;
      hw = v;
    end else m_hits++;
    node = 0;
    for (int l = LG - 1; l >= 0; l--) begin
      bt = (hw >> l) & 1;
      m_tree[s][node] = (bt == 0);
      node = 2 * node + 1 + bt;
    end
    exp_rdata = m_line[s][hw][32*wd +: 32];
    if (is_wr) begin
      for (int k = 0; k < 4; k++)
        if (b[k]) m_line[s][hw][32*wd + 8*k +: 8] = d[8*k +: 8];
      m_dirty[s][hw] = 1;
    end
  endtask

  // One request, checked cycle by cycle. Called and returns at posedge+1.
  task automatic txn(input logic [31:0] a, input bit is_wr, input logic [3:0] b,
                     input logic [31:0] d, output int lat, output bit wbs,
                     output logic [31:0] wb_a, output logic [255:0] wb_l,
                     output logic [31:0] rd_out);
    int ph;
    bit done, exp_r;
    chk("hit_count", hitc, 32'(m_hits));
    chk("miss_count", missc, 32'(m_misses));
    model_access(a, is_wr, b, d);
    addr = a; wr = is_wr; be = b; wdata = d;
    rd = is_wr ? 1'($urandom_range(0, 1)) : 1'b1;
    lat = -1; wbs = 0; wb_a = '0; wb_l = '0; rd_out = '0; ph = 0; done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      exp_r = (ph == 0 && exp_hit) || ph == 3;
      chk("cpu_resp", resp, exp_r);
      chk("ca_write", ca_wr, ph == 1);
      chk("ca_read", ca_rd, ph == 2);
      if (ca_wr && !wbs) begin wbs = 1; wb_a = ca_addr; wb_l = ca_wdata; end
      if (ph == 1) begin
        chk("wb_addr", ca_addr, exp_wb_addr);
        chk("wb_data", ca_wdata, exp_wb_line);
      end
      if (ph == 2) chk("fill_addr", ca_addr, exp_fill_addr);
      if (exp_r || resp) begin
        if (!is_wr) chk("rdata", rdata, exp_rdata);
        rd_out = rdata; lat = c; done = 1;
        break;
      end
      case (ph)
        0: ph = exp_wb ? 1 : 2;
        1: if (ca_resp) ph = 2;
        2: if (ca_resp) ph = 3;
        default: ;
      endcase
    end
    chk("txn_done", done, 1'b1);
    @(posedge clk); #1;
    rd = 0; wr = 0;
  endtask

  task automatic do_reset();
    rd = 0; wr = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    bit wbs, seen;
    logic [31:0] wb_a, rdv, a;
    logic [255:0] wb_l, tmp;
    logic [31:0] d1_seq [4];
    rst = 1; rd = 0; wr = 0; be = 0; wdata = 0; addr = 0;
    d1_addr = 0; d1_rd = 0; d1_wr = 0;
    tmp = init_line(32'h100);
    tmp[31:0] = 32'hDEADBEEF;
    mem[32'h100] = tmp; m_mem[32'h100] = tmp;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    model_reset();
    @(negedge clk);
    chk("rst_resp", resp, 1'b0);
    chk("rst_ca_read", ca_rd, 1'b0);
    chk("rst_ca_write", ca_wr, 1'b0);
    chk("rst_hit_count", hitc, 32'd0);
    chk("rst_miss_count", missc, 32'd0);
    @(posedge clk); #1;

    // Cold read, re-read, write hit, re-read.
    set_delay(2);
    txn(32'h100, 0, 4'h0, 0, lat, wbs, wb_a, wb_l, rdv);
    chk("cold_rdata", rdv, 32'hDEADBEEF);
    chk("cold_latency", 32'(lat), 32'd4);
    chk("cold_miss_count", missc, 32'd1);
    txn(32'h100, 0, 4'h0, 0, lat, wbs, wb_a, wb_l, rdv);
    chk("rehit_latency", 32'(lat), 32'd0);
    chk("rehit_hit_count", hitc, 32'd1);
    txn(32'h100, 1, 4'b0011, 32'h12345678, lat, wbs, wb_a, wb_l, rdv);
    chk("wrhit_latency", 32'(lat), 32'd0);
    txn(32'h100, 0, 4'h0, 0, lat, wbs, wb_a, wb_l, rdv);
    chk("wrhit_rdata", rdv, 32'hDEAD5678);

    // Tree PLRU eviction of a clean way.
    set_delay(-1);
    do_reset();
    for (int i = 0; i < 5; i++)
      txn(32'(i) << 8, 0, 4'h0, 0, lat, wbs, wb_a, wb_l, rdv);
    chk("plru_no_wb", wbs, 1'b0);
    txn(32'h100, 0, 4'h0, 0, lat, wbs, wb_a, wb_l, rdv);
    chk("plru_keep_latency", 32'(lat), 32'd0);
    txn(32'h000, 0, 4'h0, 0, lat, wbs, wb_a, wb_l, rdv);
    chk("plru_evicted_miss_count", missc, 32'd6);

    // Dirty eviction.
    do_reset();
    txn(32'h000, 1, 4'hF, 32'hA5A5A5A5, lat, wbs, wb_a, wb_l, rdv);
    for (int i = 1; i < 4; i++)
      txn(32'(i) << 8, 0, 4'h0, 0, lat, wbs, wb_a, wb_l, rdv);
    txn(32'h400, 0, 4'h0, 0, lat, wbs, wb_a, wb_l, rdv);
    chk("dirty_wb_seen", wbs, 1'b1);
    chk("dirty_wb_addr", wb_a, 32'h0);
    chk("dirty_wb_word0", wb_l[31:0], 32'hA5A5A5A5);
    chk("dirty_miss_count", missc, 32'd5);

    // Reset while a fill is outstanding.
    do_reset();
    set_delay(10);
    addr = 32'h500; rd = 1; seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = ca_rd;
    end
    chk("midalloc_read_seen", seen, 1'b1);
    @(posedge clk); #1;
    rst = 1; rd = 0;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("midalloc_ca_read", ca_rd, 1'b0);
    chk("midalloc_ca_write", ca_wr, 1'b0);
    chk("midalloc_miss_count", missc, 32'd0);
    chk("midalloc_hit_count", hitc, 32'd0);
    model_reset();
    set_delay(-1);
    @(posedge clk); #1;
    txn(32'h500, 0, 4'h0, 0, lat, wbs, wb_a, wb_l, rdv);
    chk("midalloc_reread_miss", missc, 32'd1);

    // Randomized traffic over two sets and six tags per set.
    for (int n = 0; n < 400; n++) begin
      a = {24'($urandom_range(0, 5)), 3'($urandom_range(0, 1)), 3'($urandom), 2'($urandom)};
      txn(a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom,
          lat, wbs, wb_a, wb_l, rdv);
      repeat ($urandom_range(0, 1)) begin
        @(negedge clk);
        chk("idle_resp", resp, 1'b0);
        @(posedge clk); #1;
      end
    end
    chk("final_hit_count", hitc, 32'(m_hits));
    chk("final_miss_count", missc, 32'(m_misses));

    // Direct-mapped build: alternating conflicting lines always miss.
    d1_seq = '{32'h000, 32'h100, 32'h000, 32'h100};
    for (int i = 0; i < 4; i++) begin
      d1_addr = d1_seq[i]; d1_rd = 1; seen = 0;
      for (int c = 0; c < 30 && !seen; c++) begin
        @(negedge clk);
        if (d1_cresp) begin
          seen = 1;
          chk("d1_rdata", d1_rdout, d1_seq[i]);
        end
      end
      chk("d1_done", seen, 1'b1);
      @(posedge clk); #1;
      d1_rd = 0;
    end
    chk("d1_miss_count", d1_missc, 32'd4);
    chk("d1_hit_count", d1_hitc, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
